// File: rtl/window_cmp_tracker_pkg.sv
// Shared types and helpers for the window compare tracker.
// Holds the tracker FSM encoding and the count-width helper.
// Imported by the interface and the top module.
package cmp_tracker_pkg;

   typedef enum logic [1:0] {
      ST_FIRST = 2'd0,
      ST_ACCUM = 2'd1,
      ST_HOLD  = 2'd2
   } state_e;

   // Width of the rise/fall/flat counters. These counters never exceed
   // WINDOW-1, so $clog2(WINDOW) bits always suffice. Clamp to 1 bit so
   // that a degenerate window still gives a legal vector width.
   function automatic int cnt_width(input int window);
      return (window < 2) ? 1 : $clog2(window);
   endfunction

endpackage

// File: rtl/window_cmp_tracker_if.sv
// Sample-in / summary-out bundle for window_cmp_tracker.
// slave: tracker side (consumes samples, produces summaries).
// master: producer/consumer side (drives samples, takes summaries).
interface window_cmp_tracker_if
#(
   parameter int WIDTH  = 4,
   parameter int WINDOW = 8
);
   import cmp_tracker_pkg::*;

   localparam int CW = cnt_width(WINDOW);

   logic             in_valid;
   logic [WIDTH-1:0] in_data;
   logic             in_ready;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_max;
   logic [WIDTH-1:0] out_min;
   logic [CW-1:0]    rise_cnt;
   logic [CW-1:0]    fall_cnt;
   logic [CW-1:0]    flat_cnt;

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_max, out_min, rise_cnt, fall_cnt, flat_cnt
   );

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_max, out_min, rise_cnt, fall_cnt, flat_cnt
   );

endinterface

// File: rtl/window_cmp_tracker_mag_compare.sv
// Unsigned magnitude comparator: exactly one of lt/gt/eq is high.
// Latency: purely combinational.
// Backpressure: none.
// Ports: a, b (WIDTH-bit operands); lt = a<b, gt = a>b, eq = a==b.
module mag_compare
#(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             lt,
   output logic             gt,
   output logic             eq
);

   assign lt = (a <  b);
   assign gt = (a >  b);
   assign eq = (a == b);

endmodule

// File: rtl/window_cmp_tracker.sv
// Tracks max/min and rise/fall/flat counts over windows of WINDOW samples.
// Latency: summary valid (registered) the cycle after the WINDOW-th accept.
// Backpressure: in_ready drops while a summary waits for out_ready.
// Ports: clk, rst (async, active-high); bus = window_cmp_tracker_if.slave
//        carrying in_valid/in_data/in_ready and out_valid/out_ready plus
//        the out_max/out_min/rise_cnt/fall_cnt/flat_cnt summary.
module window_cmp_tracker
   import cmp_tracker_pkg::*;
#(
   parameter int WIDTH  = 4,
   parameter int WINDOW = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   window_cmp_tracker_if.slave  bus
);

   localparam int            CW       = cnt_width(WINDOW);
   localparam logic [CW-1:0] LAST_CNT = CW'(WINDOW - 1);
   localparam logic [CW-1:0] ONE      = CW'(1);

   if (WINDOW < 2 || WINDOW > 255) begin : g_bad_window
      $error("window_cmp_tracker: WINDOW must be in 2..255");
   end

   state_e           state_q, state_d;
   logic [WIDTH-1:0] max_q, max_d;
   logic [WIDTH-1:0] min_q, min_d;
   logic [WIDTH-1:0] prev_q, prev_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [CW-1:0]    rise_q, rise_d;
   logic [CW-1:0]    fall_q, fall_d;
   logic [CW-1:0]    flat_q, flat_d;
   logic             out_valid_q, out_valid_d;

   logic accept;

   // Three comparator instances: the trend compare against the previous
   // sample, and separate max and min compares so both extremes can be
   // updated from the same sample in one cycle. Only one output of the
   // max/min instances is needed; the rest are left to unused_* nets.
   logic prev_lt, prev_gt, prev_eq;
   logic max_gt, min_lt;
   logic unused_max_lt, unused_max_eq, unused_min_gt, unused_min_eq;

   mag_compare #(.WIDTH(WIDTH)) u_cmp_prev (
      .a  (bus.in_data),
      .b  (prev_q),
      .lt (prev_lt),
      .gt (prev_gt),
      .eq (prev_eq)
   );

   mag_compare #(.WIDTH(WIDTH)) u_cmp_max (
      .a  (bus.in_data),
      .b  (max_q),
      .lt (unused_max_lt),
      .gt (max_gt),
      .eq (unused_max_eq)
   );

   mag_compare #(.WIDTH(WIDTH)) u_cmp_min (
      .a  (bus.in_data),
      .b  (min_q),
      .lt (min_lt),
      .gt (unused_min_gt),
      .eq (unused_min_eq)
   );

   // in_ready depends on state alone, so it never combinationally
   // follows in_valid or out_ready.
   assign bus.in_ready  = (state_q != ST_HOLD);
   assign accept        = bus.in_valid && bus.in_ready;

   assign bus.out_valid = out_valid_q;
   assign bus.out_max   = max_q;
   assign bus.out_min   = min_q;
   assign bus.rise_cnt  = rise_q;
   assign bus.fall_cnt  = fall_q;
   assign bus.flat_cnt  = flat_q;

   always_comb begin
      state_d = state_q;
      max_d   = max_q;
      min_d   = min_q;
      prev_d  = prev_q;
      cnt_d   = cnt_q;
      rise_d  = rise_q;
      fall_d  = fall_q;
      flat_d  = flat_q;

      case (state_q)
         ST_FIRST: begin
            if (accept) begin
               max_d   = bus.in_data;
               min_d   = bus.in_data;
               prev_d  = bus.in_data;
               rise_d  = '0;
               fall_d  = '0;
               flat_d  = '0;
               cnt_d   = ONE;
               state_d = ST_ACCUM;
            end
         end
         ST_ACCUM: begin
            if (accept) begin
               if (prev_gt) rise_d = rise_q + ONE;
               if (prev_lt) fall_d = fall_q + ONE;
               if (prev_eq) flat_d = flat_q + ONE;
               if (max_gt)  max_d  = bus.in_data;
               if (min_lt)  min_d  = bus.in_data;
               prev_d = bus.in_data;
               // The final sample would push cnt to WINDOW, which may not
               // fit in CW bits; park it at zero instead. FIRST reloads it.
               if (cnt_q == LAST_CNT) begin
                  cnt_d   = '0;
                  state_d = ST_HOLD;
               end else begin
                  cnt_d   = cnt_q + ONE;
               end
            end
         end
         ST_HOLD: begin
            if (bus.out_ready) state_d = ST_FIRST;
         end
         default: state_d = ST_FIRST;
      endcase

      out_valid_d = (state_d == ST_HOLD);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_FIRST;
         max_q       <= '0;
         min_q       <= '0;
         prev_q      <= '0;
         cnt_q       <= '0;
         rise_q      <= '0;
         fall_q      <= '0;
         flat_q      <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         max_q       <= max_d;
         min_q       <= min_d;
         prev_q      <= prev_d;
         cnt_q       <= cnt_d;
         rise_q      <= rise_d;
         fall_q      <= fall_d;
         flat_q      <= flat_d;
         out_valid_q <= out_valid_d;
      end
   end

endmodule

// File: tb/tb_window_cmp_tracker.sv
// Self-checking bench for window_cmp_tracker (WIDTH=4, WINDOW=4).
// Directed windows, reset cases, an exhaustive pair sweep and a random phase,
// all checked every cycle against a queue-based window model.
module tb_window_cmp_tracker;

   localparam int WIDTH  = 4;
   localparam int WINDOW = 4;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   window_cmp_tracker_if #(.WIDTH(WIDTH), .WINDOW(WINDOW)) bus ();

   window_cmp_tracker #(.WIDTH(WIDTH), .WINDOW(WINDOW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int total = 0;
   int bad   = 0;

   // Reference model: samples accepted into the open window, and the
   // summary the tracker owes while a finished window is being held.
   int win_q[$];
   bit m_hold;
   int m_max, m_min, m_rise, m_fall, m_flat;

   task automatic chk(input string tag, input int obs, input int exp);
      total++;
      if (obs != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic summarize();
      m_max  = win_q[0];
      m_min  = win_q[0];
      m_rise = 0;
      m_fall = 0;
      m_flat = 0;
      for (int i = 1; i < win_q.size(); i++) begin
         if (win_q[i] > win_q[i-1])      m_rise++;
         else if (win_q[i] < win_q[i-1]) m_fall++;
         else                            m_flat++;
         if (win_q[i] > m_max) m_max = win_q[i];
         if (win_q[i] < m_min) m_min = win_q[i];
      end
   endtask

   // One clock cycle, entered and left at a falling edge.
   task automatic step(input bit iv, input int id, input bit ordy);
      bus.in_valid  = iv;
      bus.in_data   = iv ? 4'(id) : 4'($urandom);
      bus.out_ready = ordy;
      #1;
      chk("in_ready", int'(bus.in_ready), int'(!m_hold));
      chk("out_valid", int'(bus.out_valid), int'(m_hold));
      if (m_hold) begin
         chk("out_max", int'(bus.out_max), m_max);
         chk("out_min", int'(bus.out_min), m_min);
         chk("rise_cnt", int'(bus.rise_cnt), m_rise);
         chk("fall_cnt", int'(bus.fall_cnt), m_fall);
         chk("flat_cnt", int'(bus.flat_cnt), m_flat);
      end
      if (iv && !m_hold) begin
         win_q.push_back(id);
         if (win_q.size() == WINDOW) begin
            summarize();
            win_q.delete();
            m_hold = 1'b1;
         end
      end else if (m_hold && ordy) begin
         m_hold = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   // Present one sample until the model says it has been taken.
   task automatic send(input int d, input bit ordy);
      bit took;
      for (int g = 0; g < 20; g++) begin
         took = !m_hold;
         step(1'b1, d, ordy);
         if (took) return;
      end
      chk("send_timeout", 0, 1);
   endtask

   task automatic idle(input int n, input bit ordy);
      for (int i = 0; i < n; i++) step(1'b0, 0, ordy);
   endtask

   // Assert rst between clock edges and check the clear happens at once.
   task automatic do_reset();
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;
      rst = 1'b1;
      #1;
      chk("rst_out_valid", int'(bus.out_valid), 0);
      chk("rst_in_ready", int'(bus.in_ready), 1);
      chk("rst_out_max", int'(bus.out_max), 0);
      chk("rst_out_min", int'(bus.out_min), 0);
      chk("rst_rise", int'(bus.rise_cnt), 0);
      chk("rst_fall", int'(bus.fall_cnt), 0);
      chk("rst_flat", int'(bus.flat_cnt), 0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      win_q.delete();
      m_hold = 1'b0;
   endtask

   initial begin
      m_hold = 1'b0;
      do_reset();

      // Mixed trend, back-to-back, summary taken immediately.
      send(3, 1); send(7, 1); send(7, 1); send(2, 1);
      idle(3, 1);

      // Held summary with a sample waiting; it is taken one cycle after release.
      send(1, 0); send(2, 0); send(3, 0); send(4, 0);
      for (int i = 0; i < 5; i++) step(1'b1, 9, 1'b0);
      step(1'b1, 9, 1'b1);
      send(9, 1); send(6, 1); send(6, 1); send(12, 1);
      idle(2, 1);

      // Full-scale extremes.
      send(15, 1); send(0, 1); send(15, 1); send(0, 1);
      idle(2, 1);

      // Ties with one-cycle bubbles.
      for (int i = 0; i < 4; i++) begin
         send(5, 1);
         step(1'b0, 0, 1'b1);
      end
      idle(2, 1);

      // Reset mid-window discards the partial window.
      send(8, 1); send(1, 1);
      do_reset();
      send(1, 1); send(2, 1); send(3, 1); send(4, 1);
      idle(2, 1);

      // Reset while a summary is pending.
      send(10, 0); send(11, 0); send(12, 0); send(13, 0);
      step(1'b0, 0, 1'b0);
      do_reset();
      idle(1, 1);

      // Every (a,b) pair as window a,b,b,b.
      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            send(a, 1);
            for (int k = 0; k < 3; k++) send(b, 1);
         end
      end
      idle(2, 1);

      // Random valid, data and out_ready.
      for (int i = 0; i < 400; i++) begin
         step(bit'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
              bit'($urandom_range(0, 3) != 0));
      end
      idle(3, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
